// File: rtl/alu_op_sequencer_if.sv
// Request, operand bus, ALU control and result-return signals of alu_op_sequencer.
// The sequencer uses the slave modport; whoever issues requests and models the ALU uses master.
interface alu_op_sequencer_if #(
   parameter int unsigned BITS = 32
);
   logic                req_valid;
   logic                req_ready;
   logic [3:0]          req_op;
   logic [BITS-1:0]     bus_in;
   logic                opb_valid;
   logic [11:0]         alu_ctrl;
   logic [BITS-1:0]     alu_x;
   logic [BITS-1:0]     alu_y;
   logic [2*BITS-1:0]   alu_result;
   logic                out_valid;
   logic                out_ready;
   logic [BITS-1:0]     out_data;
   logic                out_last;
   logic                busy;
   logic                err_op;

   modport slave (
      input  req_valid, req_op, bus_in, opb_valid, alu_result, out_ready,
      output req_ready, alu_ctrl, alu_x, alu_y, out_valid, out_data, out_last, busy, err_op
   );

   modport master (
      output req_valid, req_op, bus_in, opb_valid, alu_result, out_ready,
      input  req_ready, alu_ctrl, alu_x, alu_y, out_valid, out_data, out_last, busy, err_op
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Operand/result sequencer around the ALU: latches Y then X, holds the one-hot control for
// EXEC_CYCLES cycles, captures the double-width result and returns it over valid/ready.
module alu_op_sequencer #(
   parameter int unsigned BITS        = 32,
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   alu_op_sequencer_if.slave      bus
);
   typedef enum logic [2:0] {StIdle, StLoadX, StExec, StOutLo, StOutHi} state_t;

   localparam logic [3:0] LastCnt = 4'(EXEC_CYCLES - 1);

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_op;
   logic [BITS-1:0]     r_y, r_x;
   logic [2*BITS-1:0]   r_z;
   logic [3:0]          r_cnt;
   logic                r_err;

   logic                w_illegal, w_unary, w_last, w_two_word;
   logic [11:0]         w_onehot;

   assign w_illegal  = (bus.req_op > 4'd11);
   assign w_unary    = (bus.req_op == 4'd10) || (bus.req_op == 4'd11);
   assign w_last     = (r_cnt == LastCnt);
   assign w_two_word = (r_op == 4'd2) || (r_op == 4'd3);
   assign w_onehot   = 12'd1 << r_op;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_op    <= '0;
         r_y     <= '0;
         r_x     <= '0;
         r_z     <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= 1'b0;
         // Counter only runs inside EXEC; it is zero on every EXEC entry.
         r_cnt   <= (r_state == StExec && !w_last) ? r_cnt + 4'd1 : 4'd0;
         case (r_state)
            StIdle: begin
               if (bus.req_valid) begin
                  r_op  <= bus.req_op;
                  r_y   <= bus.bus_in;
                  r_err <= w_illegal;
                  if (w_unary) r_x <= '0;
               end
            end
            StLoadX: if (bus.opb_valid) r_x <= bus.bus_in;
            StExec:  if (w_last) r_z <= bus.alu_result;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      bus.req_ready = 1'b0;
      bus.alu_ctrl  = '0;
      bus.alu_x     = '0;
      bus.alu_y     = '0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_last  = 1'b0;
      bus.busy      = (r_state != StIdle);
      bus.err_op    = r_err;
      case (r_state)
         StIdle: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid && !w_illegal) begin
               w_state_nxt = w_unary ? StExec : StLoadX;
            end
         end
         StLoadX: begin
            if (bus.opb_valid) w_state_nxt = StExec;
         end
         StExec: begin
            bus.alu_ctrl = w_onehot;
            bus.alu_x    = r_x;
            bus.alu_y    = r_y;
            if (w_last) w_state_nxt = StOutLo;
         end
         StOutLo: begin
            bus.out_valid = 1'b1;
            bus.out_data  = r_z[BITS-1:0];
            bus.out_last  = !w_two_word;
            if (bus.out_ready) w_state_nxt = w_two_word ? StOutHi : StIdle;
         end
         StOutHi: begin
            bus.out_valid = 1'b1;
            bus.out_data  = r_z[2*BITS-1:BITS];
            bus.out_last  = 1'b1;
            if (bus.out_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table on an EXEC_CYCLES=1 instance plus
// hand sequences for illegal op, backpressure, mid-op reset and an EXEC_CYCLES=3 instance.
module tb_alu_op_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_op_sequencer_if #(.BITS(32)) u_if1 ();
   alu_op_sequencer_if #(.BITS(32)) u_if3 ();

   alu_op_sequencer #(.BITS(32), .EXEC_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(u_if1));
   alu_op_sequencer #(.BITS(32), .EXEC_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(u_if3));

   // Reference ALU for the single-cycle instance; sub/div take Y as the left operand.
   logic [63:0] w_model;
   always_comb begin
      w_model = '0;
      case (u_if1.alu_ctrl)
         12'h001: w_model = {32'h0, u_if1.alu_x} + {32'h0, u_if1.alu_y};
         12'h002: w_model = {32'h0, u_if1.alu_y - u_if1.alu_x};
         12'h004: w_model = {32'h0, u_if1.alu_x} * {32'h0, u_if1.alu_y};
         12'h008: w_model = (u_if1.alu_x != 0) ?
                            {u_if1.alu_y % u_if1.alu_x, u_if1.alu_y / u_if1.alu_x} : 64'h0;
         12'h010: w_model = {32'h0, u_if1.alu_y >> u_if1.alu_x[4:0]};
         12'h020: w_model = {32'h0, u_if1.alu_y << u_if1.alu_x[4:0]};
         12'h100: w_model = {32'h0, u_if1.alu_y & u_if1.alu_x};
         12'h200: w_model = {32'h0, u_if1.alu_y | u_if1.alu_x};
         12'h400: w_model = {32'h0, 32'h0 - u_if1.alu_y};
         12'h800: w_model = {32'h0, ~u_if1.alu_y};
         default: w_model = '0;
      endcase
   end
   assign u_if1.alu_result = w_model;

   logic [63:0] r3_res;
   assign u_if3.alu_result = r3_res;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] y;
      logic [31:0] x;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Full transaction on the EXEC_CYCLES=1 instance with inline checks.
   task automatic run1(input vec_t v);
      logic two;
      logic unary;
      two   = (v.op == 4'd2) || (v.op == 4'd3);
      unary = (v.op == 4'd10) || (v.op == 4'd11);
      @(negedge clk);
      chk("req_ready idle", {63'h0, u_if1.req_ready}, 64'd1);
      u_if1.req_valid = 1'b1;
      u_if1.req_op    = v.op;
      u_if1.bus_in    = v.y;
      @(negedge clk);
      u_if1.req_valid = 1'b0;
      if (!unary) begin
         chk("load_x ctrl", {52'h0, u_if1.alu_ctrl}, 64'h0);
         chk("load_x busy", {63'h0, u_if1.busy}, 64'd1);
         u_if1.opb_valid = 1'b1;
         u_if1.bus_in    = v.x;
         @(negedge clk);
         u_if1.opb_valid = 1'b0;
      end
      u_if1.bus_in = 32'hDEAD_BEEF;
      chk("exec ctrl", {52'h0, u_if1.alu_ctrl}, 64'd1 << v.op);
      chk("exec x", {32'h0, u_if1.alu_x}, unary ? 64'h0 : {32'h0, v.x});
      chk("exec y", {32'h0, u_if1.alu_y}, {32'h0, v.y});
      @(negedge clk);
      chk("lo valid", {63'h0, u_if1.out_valid}, 64'd1);
      chk("lo ctrl off", {52'h0, u_if1.alu_ctrl}, 64'h0);
      chk("lo data", {32'h0, u_if1.out_data}, {32'h0, v.lo});
      chk("lo last", {63'h0, u_if1.out_last}, two ? 64'd0 : 64'd1);
      u_if1.out_ready = 1'b1;
      @(negedge clk);
      if (two) begin
         chk("hi valid", {63'h0, u_if1.out_valid}, 64'd1);
         chk("hi data", {32'h0, u_if1.out_data}, {32'h0, v.hi});
         chk("hi last", {63'h0, u_if1.out_last}, 64'd1);
         @(negedge clk);
      end
      u_if1.out_ready = 1'b0;
      chk("done busy", {63'h0, u_if1.busy}, 64'd0);
      chk("done valid", {63'h0, u_if1.out_valid}, 64'd0);
   endtask

   initial begin
      vecs[0]  = '{op: 4'd0,  y: 32'd5,         x: 32'd7,         lo: 32'd12,        hi: 32'd0};
      vecs[1]  = '{op: 4'd0,  y: 32'hFFFF_FFFF, x: 32'd1,         lo: 32'd0,         hi: 32'd1};
      vecs[2]  = '{op: 4'd1,  y: 32'd10,        x: 32'd3,         lo: 32'd7,         hi: 32'd0};
      vecs[3]  = '{op: 4'd2,  y: 32'd2,         x: 32'h8000_0001, lo: 32'h2,         hi: 32'h1};
      vecs[4]  = '{op: 4'd3,  y: 32'd100,       x: 32'd7,         lo: 32'd14,        hi: 32'd2};
      vecs[5]  = '{op: 4'd4,  y: 32'h80,        x: 32'd3,         lo: 32'h10,        hi: 32'd0};
      vecs[6]  = '{op: 4'd5,  y: 32'h1,         x: 32'd4,         lo: 32'h10,        hi: 32'd0};
      vecs[7]  = '{op: 4'd8,  y: 32'hF0F0,      x: 32'hFF00,      lo: 32'hF000,      hi: 32'd0};
      vecs[8]  = '{op: 4'd9,  y: 32'hF0F0,      x: 32'h0F0F,      lo: 32'hFFFF,      hi: 32'd0};
      vecs[9]  = '{op: 4'd11, y: 32'h0F0F_0F0F, x: 32'd0,         lo: 32'hF0F0_F0F0, hi: 32'd0};
      vecs[10] = '{op: 4'd10, y: 32'd1,         x: 32'd0,         lo: 32'hFFFF_FFFF, hi: 32'd0};

      reset = 1'b1;
      u_if1.req_valid = 1'b0; u_if1.req_op = '0; u_if1.bus_in = '0;
      u_if1.opb_valid = 1'b0; u_if1.out_ready = 1'b0;
      u_if3.req_valid = 1'b0; u_if3.req_op = '0; u_if3.bus_in = '0;
      u_if3.opb_valid = 1'b0; u_if3.out_ready = 1'b0;
      r3_res = '0;
      repeat (2) @(negedge clk);
      chk("rst req_ready", {63'h0, u_if1.req_ready}, 64'd1);
      chk("rst busy", {63'h0, u_if1.busy}, 64'd0);
      chk("rst valid", {63'h0, u_if1.out_valid}, 64'd0);
      chk("rst ctrl", {52'h0, u_if1.alu_ctrl}, 64'h0);
      chk("rst xy", {u_if1.alu_x, u_if1.alu_y}, 64'h0);
      chk("rst err", {63'h0, u_if1.err_op}, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) run1(vecs[i]);

      // Illegal opcode: one-cycle error pulse, no state change.
      @(negedge clk);
      u_if1.req_valid = 1'b1;
      u_if1.req_op    = 4'd13;
      @(negedge clk);
      u_if1.req_valid = 1'b0;
      chk("illegal err", {63'h0, u_if1.err_op}, 64'd1);
      chk("illegal busy", {63'h0, u_if1.busy}, 64'd0);
      chk("illegal ctrl", {52'h0, u_if1.alu_ctrl}, 64'h0);
      @(negedge clk);
      chk("illegal err drop", {63'h0, u_if1.err_op}, 64'd0);
      chk("illegal ctrl2", {52'h0, u_if1.alu_ctrl}, 64'h0);
      run1(vecs[0]);

      // Backpressure in OUT_LO.
      @(negedge clk);
      u_if1.req_valid = 1'b1; u_if1.req_op = 4'd0; u_if1.bus_in = 32'd20;
      @(negedge clk);
      u_if1.req_valid = 1'b0; u_if1.opb_valid = 1'b1; u_if1.bus_in = 32'd22;
      @(negedge clk);
      u_if1.opb_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp valid", {63'h0, u_if1.out_valid}, 64'd1);
         chk("bp data", {32'h0, u_if1.out_data}, 64'd42);
         chk("bp last", {63'h0, u_if1.out_last}, 64'd1);
      end
      u_if1.out_ready = 1'b1;
      @(negedge clk);
      u_if1.out_ready = 1'b0;
      chk("bp done", {63'h0, u_if1.out_valid}, 64'd0);

      // Reset while in EXEC discards the operation.
      u_if1.req_valid = 1'b1; u_if1.req_op = 4'd2; u_if1.bus_in = 32'd3;
      @(negedge clk);
      u_if1.req_valid = 1'b0; u_if1.opb_valid = 1'b1; u_if1.bus_in = 32'd4;
      @(negedge clk);
      u_if1.opb_valid = 1'b0;
      chk("pre-rst ctrl", {52'h0, u_if1.alu_ctrl}, 64'h004);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst ctrl", {52'h0, u_if1.alu_ctrl}, 64'h0);
      chk("midrst valid", {63'h0, u_if1.out_valid}, 64'd0);
      chk("midrst busy", {63'h0, u_if1.busy}, 64'd0);
      chk("midrst ready", {63'h0, u_if1.req_ready}, 64'd1);
      chk("midrst xy", {u_if1.alu_x, u_if1.alu_y}, 64'h0);
      chk("midrst last", {63'h0, u_if1.out_last}, 64'd0);
      run1(vecs[2]);

      // EXEC_CYCLES=3: control held 3 cycles, Z sampled only at the end of the third.
      @(negedge clk);
      u_if3.req_valid = 1'b1; u_if3.req_op = 4'd9; u_if3.bus_in = 32'h11;
      @(negedge clk);
      u_if3.req_valid = 1'b0; u_if3.opb_valid = 1'b1; u_if3.bus_in = 32'h22;
      @(negedge clk);
      u_if3.opb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("e3 ctrl", {52'h0, u_if3.alu_ctrl}, 64'h200);
         chk("e3 valid", {63'h0, u_if3.out_valid}, 64'd0);
         r3_res = (i == 0) ? 64'hAAAA_AAAA_0000_0001 :
                  (i == 1) ? 64'hBBBB_BBBB_0000_0002 : 64'hCCCC_CCCC_0000_0033;
         @(negedge clk);
      end
      r3_res = 64'hDDDD_DDDD_0000_0044;
      chk("e3 ctrl off", {52'h0, u_if3.alu_ctrl}, 64'h0);
      chk("e3 out valid", {63'h0, u_if3.out_valid}, 64'd1);
      chk("e3 out data", {32'h0, u_if3.out_data}, 64'h33);
      chk("e3 out last", {63'h0, u_if3.out_last}, 64'd1);
      u_if3.out_ready = 1'b1;
      @(negedge clk);
      u_if3.out_ready = 1'b0;
      chk("e3 done busy", {63'h0, u_if3.busy}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle operand/result sequencer placed directly upstream and downstream of the ALU. It accepts an operation request, latches operand Y and then operand X from the shared bus, and drives the ALU's one-hot control and operands for a fixed number of cycles. It captures the 2*BITS-wide ALU result into a Z register and returns it to the bus through a valid/ready handshake: Z low word only for most ops, low then high word for multiply and divide.

Parameters:
BITS, 32, datapath word width
EXEC_CYCLES, 1, cycles alu_ctrl is held active before Z capture (legal range 1..15)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  operation request valid
req_ready  output  1  sequencer can accept a request
req_op  input  4  operation index 0..11 (0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not)
bus_in  input  BITS  bus data: Y operand at request accept, X operand when opb_valid
opb_valid  input  1  bus_in holds the second operand
alu_ctrl  output  12  one-hot ALU control; bit index equals req_op
alu_x  output  BITS  ALU X operand
alu_y  output  BITS  ALU Y operand
alu_result  input  2*BITS  ALU operationResult
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  BITS  Z low word, then Z high word for mul/div
out_last  output  1  qualifies the final word of a result
busy  output  1  high whenever state is not IDLE
err_op  output  1  one-cycle pulse on an illegal opcode

Behaviour:
- Reset: state IDLE; Y, X, Z, op registers = 0; alu_ctrl = 0; alu_x = alu_y = 0; out_valid, out_last, err_op, busy = 0; req_ready = 1. Reset takes priority in every state, including mid-EXEC and mid-output; any in-flight result is discarded.
- States: IDLE, LOAD_X, EXEC, OUT_LO, OUT_HI.
- IDLE: req_ready = 1. A request is accepted when req_valid && req_ready. On accept, op <= req_op and Y <= bus_in.
  - op 12..15: err_op = 1 for the next cycle; state stays IDLE; no ALU activity.
  - op 10 or 11 (unary): X <= 0; go to EXEC.
  - Any other legal op: go to LOAD_X.
- LOAD_X: waits indefinitely. On opb_valid, X <= bus_in and go to EXEC. req_ready = 0.
- EXEC: alu_ctrl = one-hot(op), alu_x = X, alu_y = Y, held for exactly EXEC_CYCLES cycles using an internal counter.
  - On the clock edge ending the last EXEC cycle, Z <= alu_result and go to OUT_LO.
  - alu_ctrl = 0 and alu_x = alu_y = 0 in every other state.
- OUT_LO: out_valid = 1, out_data = Z[BITS-1:0], out_last = 1 unless op is 2 or 3.
  - On out_ready: op 2/3 go to OUT_HI, otherwise go to IDLE.
- OUT_HI: out_valid = 1, out_data = Z[2*BITS-1:BITS], out_last = 1. On out_ready, go to IDLE.
- Backpressure: while out_valid && !out_ready, out_data and out_last are held stable.
- Z high half is captured for every op but is only output for mul/div; for add, Z[BITS] holds the carry.
- Latency: request accepted at edge T, opb_valid sampled at edge T+1. alu_ctrl is active during cycles T+1 .. T+EXEC_CYCLES after that edge. out_valid rises in the cycle after Z capture.
- Unary ops skip LOAD_X, so they are one cycle shorter.
- req_valid is ignored outside IDLE. opb_valid is ignored outside LOAD_X.
- Back-to-back operation: returning to IDLE on out_ready allows the next accept on the following edge. There is no overlap between operations.

Test Plan:
- Add: req_op=0, bus_in=5 at accept, opb_valid with bus_in=7; bench ALU model returns 12 -> alu_ctrl=12'h001 for exactly 1 cycle; out_data=32'd12 with out_last=1; single output word; busy returns to 0.
- Mul two-word: req_op=2, bench drives alu_result=64'h0000_0001_0000_0002 -> out_data=32'h2 (out_last=0), then 32'h1 (out_last=1); alu_ctrl=12'h004 during EXEC.
- EXEC_CYCLES=3, op 9 -> alu_ctrl=12'h200 for exactly 3 cycles; Z captured from alu_result at the end of the 3rd cycle only, verified by changing alu_result in cycle 2.
- Unary not: req_op=11, bus_in=32'h0F0F0F0F -> no LOAD_X, alu_x=0, alu_y=32'h0F0F0F0F; alu_ctrl=12'h800 on the cycle after accept.
- Illegal op 13 -> err_op high for exactly 1 cycle, alu_ctrl stays 0, busy stays 0; the next legal request is accepted normally.
- Backpressure and reset: hold out_ready=0 for 4 cycles in OUT_LO -> out_data stable; then assert reset during EXEC of a new op -> next cycle all outputs at reset values and req_ready=1.
